// File: rtl/tick_period_meter.sv
// Tick-interval meter: reports cycles between tick strobes minus one through a one-entry
// valid/ready register. Define TICK_SYNC_EN to synchronise tick_i and count rising edges only.
module tick_period_meter #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] div_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    output logic             stalled_o
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeas
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_stalled, w_stalled_next;
    logic [CNT_W-1:0] r_div, w_div_next;
    logic             r_valid, w_valid_next;
    logic             r_overrun, w_overrun_next;
    logic             w_tick;
    logic             w_capture;
    logic             w_drop;

`ifdef TICK_SYNC_EN
    logic r_sync1, r_sync2, r_sync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync1     <= tick_i;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_sync_prev;
`else
    assign w_tick = tick_i;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_stalled_next = r_stalled;
        w_capture      = 1'b0;
        if (!en_i) begin
            w_state_next   = StIdle;
            w_cnt_next     = '0;
            w_stalled_next = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_next = StArm;
                    w_cnt_next   = '0;
                end
                StArm: begin
                    if (w_tick) begin
                        w_state_next = StMeas;
                        w_cnt_next   = '0;
                    end
                end
                StMeas: begin
                    if (w_tick) begin
                        // A tick ending a saturated interval only restarts the count.
                        w_capture      = !r_stalled;
                        w_cnt_next     = '0;
                        w_stalled_next = 1'b0;
                    end else if (r_cnt == CntMax) begin
                        w_stalled_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_div_next     = r_div;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;
        w_drop         = w_capture && r_valid && !ready_i;
        if (w_capture && !w_drop) begin
            w_div_next   = r_cnt;
            w_valid_next = 1'b1;
        end else if (r_valid && ready_i) begin
            w_valid_next = 1'b0;
        end
        if (w_drop) begin
            w_overrun_next = 1'b1;
        end else if (clear_i) begin
            w_overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_stalled <= 1'b0;
            r_div     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_stalled <= w_stalled_next;
            r_div     <= w_div_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign div_o     = r_div;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;
    assign stalled_o = r_stalled;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: hand-derived vector table, directed corner sequences and
// randomized traffic checked against a timestamp-based reference model.
module tb_tick_period_meter;

    localparam int unsigned W   = 4;
    localparam int          MAX = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         en_i;
    logic         tick_i;
    logic         clear_i;
    logic [W-1:0] div_o;
    logic         valid_o;
    logic         ready_i;
    logic         overrun_o;
    logic         stalled_o;

    int tests;
    int failed;

    // Reference model: time of the last accepted tick instead of a running counter.
    int           now;
    int           ref_t;
    bit           have_ref;
    bit           prev_en;
    bit           h1, h2, h3;
    logic [W-1:0] m_div;
    bit           m_valid;
    bit           m_ovr;
    bit           m_stall;

    typedef struct {
        bit           en;
        bit           tick;
        bit           clr;
        bit           rdy;
        bit           valid;
        logic [W-1:0] div;
        bit           ovr;
        bit           stall;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    tick_period_meter #(
        .CNT_W(W)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (en_i),
        .tick_i   (tick_i),
        .clear_i  (clear_i),
        .div_o    (div_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .overrun_o(overrun_o),
        .stalled_o(stalled_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        now      = 0;
        ref_t    = 0;
        have_ref = 1'b0;
        prev_en  = 1'b0;
        {h1, h2, h3} = 3'b000;
        m_div    = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_stall  = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit tk, input bit clr, input bit rdy);
        bit eff;
        bit rep;
        bit drop;
        int m;
        rep = 1'b0;
        m   = 0;
`ifdef TICK_SYNC_EN
        eff = h2 & ~h3;
        h3  = h2;
        h2  = h1;
        h1  = tk;
`else
        eff = tk;
`endif
        if (!en) begin
            have_ref = 1'b0;
        end else if (prev_en && eff) begin
            if (have_ref) begin
                m = now - ref_t - 1;
                rep = (m <= MAX);
            end
            have_ref = 1'b1;
            ref_t    = now;
        end
        drop = rep && m_valid && !rdy;
        if (rep && !drop) begin
            m_div   = W'(m);
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        m_stall = have_ref && ((now - ref_t) > MAX);
        prev_en = en;
        now++;
    endtask

    task automatic step(input bit en, input bit tk, input bit clr, input bit rdy);
        en_i    = en;
        tick_i  = tk;
        clear_i = clr;
        ready_i = rdy;
        @(posedge clk);
        model_edge(en, tk, clr, rdy);
        @(negedge clk);
        chk("model_div", div_o, m_div);
        chk("model_valid", valid_o, m_valid);
        chk("model_overrun", overrun_o, m_ovr);
        chk("model_stalled", stalled_o, m_stall);
    endtask

    // Called at a negedge; asserts reset asynchronously in the low phase.
    task automatic do_reset();
        en_i    = 1'b0;
        tick_i  = 1'b0;
        clear_i = 1'b0;
        ready_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_div", div_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_stalled", stalled_o, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        tests   = 0;
        failed  = 0;
        rst_n   = 1'b0;
        en_i    = 1'b0;
        tick_i  = 1'b0;
        clear_i = 1'b0;
        ready_i = 1'b0;
        model_reset();

        //            en tk cl rdy  v  div    ov st
        vecs[0]  = '{1, 0, 0, 1, 0, 4'd0, 0, 0};
        vecs[1]  = '{1, 1, 0, 1, 0, 4'd0, 0, 0};
        vecs[2]  = '{1, 0, 0, 1, 0, 4'd0, 0, 0};
        vecs[3]  = '{1, 0, 0, 1, 0, 4'd0, 0, 0};
        vecs[4]  = '{1, 0, 0, 1, 0, 4'd0, 0, 0};
        vecs[5]  = '{1, 1, 0, 1, 1, 4'd3, 0, 0};
        vecs[6]  = '{1, 0, 0, 1, 0, 4'd3, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 0, 4'd3, 0, 0};
        vecs[8]  = '{1, 0, 0, 1, 0, 4'd3, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, 1, 4'd3, 0, 0};
        vecs[10] = '{1, 1, 0, 1, 1, 4'd0, 0, 0};
        vecs[11] = '{1, 1, 0, 1, 1, 4'd0, 0, 0};
        vecs[12] = '{1, 0, 0, 1, 0, 4'd0, 0, 0};
        vecs[13] = '{1, 0, 0, 0, 0, 4'd0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 4'd0, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 0, 4'd0, 0, 0};
        vecs[16] = '{1, 1, 0, 0, 1, 4'd4, 0, 0};
        vecs[17] = '{1, 0, 0, 0, 1, 4'd4, 0, 0};
        vecs[18] = '{1, 0, 0, 0, 1, 4'd4, 0, 0};
        vecs[19] = '{1, 0, 0, 0, 1, 4'd4, 0, 0};
        vecs[20] = '{1, 0, 0, 0, 1, 4'd4, 0, 0};
        vecs[21] = '{1, 1, 0, 0, 1, 4'd4, 1, 0};
        vecs[22] = '{1, 0, 1, 0, 1, 4'd4, 0, 0};
        vecs[23] = '{1, 0, 0, 1, 0, 4'd4, 0, 0};

        @(negedge clk);
        do_reset();

`ifndef TICK_SYNC_EN
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].en, vecs[i].tick, vecs[i].clr, vecs[i].rdy);
            chk($sformatf("vec%0d_div", i), div_o, vecs[i].div);
            chk($sformatf("vec%0d_valid", i), valid_o, vecs[i].valid);
            chk($sformatf("vec%0d_overrun", i), overrun_o, vecs[i].ovr);
            chk($sformatf("vec%0d_stalled", i), stalled_o, vecs[i].stall);
        end

        // Saturation: ticks at 0, 20 (unreported) and 26.
        do_reset();
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        for (int c = 1; c < 20; c++) begin
            step(1, 0, 0, 1);
            if (c == 15) chk("sat_not_yet", stalled_o, 0);
            if (c == 16) chk("sat_stalled", stalled_o, 1);
        end
        step(1, 1, 0, 1);
        chk("sat_tick_cleared", stalled_o, 0);
        chk("sat_tick_unreported", valid_o, 0);
        for (int c = 21; c < 26; c++) step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("sat_next_valid", valid_o, 1);
        chk("sat_next_div", div_o, 5);

        // Enable drop with an unconsumed result, then re-arm and measure 7 cycles.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        for (int c = 0; c < 3; c++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        chk("endrop_keep_div", div_o, 3);
        chk("endrop_keep_valid", valid_o, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("idle_handshake", valid_o, 0);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("rearm_first_tick_silent", valid_o, 0);
        for (int c = 0; c < 6; c++) step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("rearm_div", div_o, 6);
        chk("rearm_valid", valid_o, 1);
        for (int c = 0; c < 9; c++) step(1, 0, 0, 0);
        do_reset();
`else
        // A long pulse on the synchronised input is a single tick.
        step(1, 0, 0, 1);
        for (int c = 0; c < 10; c++) step(1, 1, 0, 1);
        for (int c = 0; c < 8; c++) step(1, 0, 0, 1);
        chk("sync_pulse_single", valid_o, 0);
        do_reset();
`endif

        for (int blk = 0; blk < 16; blk++) begin
            int p;
            case ($urandom_range(0, 4))
                0: p = 0;
                1: p = 1;
                2: p = 5;
                3: p = 12;
                default: p = 25;
            endcase
            if (blk == 8) do_reset();
            for (int c = 0; c < 200; c++) begin
                step(($urandom_range(0, 49) != 0), ($urandom_range(0, p) == 0),
                     ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
Measures the interval between single-cycle tick pulses on a same-clock strobe input, such as the output of the team's tick divider. Each interval is reported in divider encoding: N cycles between ticks reports N-1, so a divider programmed with value D reads back as D. Used for self-check of divider settings and for calibrating externally sourced strobes. Results leave through a one-entry valid/ready output register.

Parameters:
CNT_W, 24, width of the interval counter and of div_o; intervals longer than 2^CNT_W cycles are flagged as stalled.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_i  input  1  measurement enable; low forces IDLE
tick_i  input  1  tick strobe, sampled each clk; every high cycle is one tick event
clear_i  input  1  synchronous clear of the sticky overrun_o flag
div_o  output  CNT_W  last measured interval minus 1
valid_o  output  1  div_o holds an unconsumed measurement
ready_i  input  1  consumer accepts div_o when valid_o && ready_i
overrun_o  output  1  sticky: a measurement was dropped because the output was full
stalled_o  output  1  counter saturated with no tick seen

Behaviour:
- Reset, asynchronous: state=IDLE, cnt=0, div_o=0, valid_o=0, overrun_o=0, stalled_o=0.
- States: IDLE, ARM, MEAS.
- IDLE: cnt held at 0. en_i=1 moves to ARM on the next cycle.
- ARM: waits for the first tick. On a tick: cnt<=0, go to MEAS. Nothing is reported for the first tick.
- MEAS: cnt increments each cycle without a tick.
- MEAS, tick cycle: capture value m = current cnt, then cnt<=0. The tick that starts an interval occurs at cycle t; the next tick occurs at t+N; m = N-1.
- Consecutive-cycle ticks (tick_i held high) report m=0 every cycle.
- Capture when the output is empty (valid_o=0): div_o<=m and valid_o<=1 on the next edge. Latency is 1 clk from the tick.
- Capture when the output is full:
  - valid_o=1 and ready_i=1 in the same cycle: the slot frees, div_o<=m, valid_o stays 1, no overrun.
  - valid_o=1 and ready_i=0: m is dropped, div_o is unchanged, overrun_o<=1.
- Handshake: transfer occurs when valid_o && ready_i. With no new capture in that cycle, valid_o<=0. div_o must not change while valid_o=1 && ready_i=0.
- Saturation: cnt stops at 2^CNT_W-1 and stalled_o<=1. The next tick is not reported; it clears stalled_o, sets cnt<=0, and the meter stays in MEAS.
- en_i falling in any state: go to IDLE next cycle, cnt<=0, stalled_o<=0. div_o, valid_o and overrun_o are retained; the handshake keeps working in IDLE.
- A tick in the same cycle en_i falls is ignored.
- clear_i: overrun_o<=0. If a drop occurs in the same cycle, the drop wins and overrun_o stays 1.
- Reset asserted mid-measurement: all state returns to reset values immediately.

Optional Feature:
TICK_SYNC_EN: when defined, tick_i passes through a 2-flop synchronizer, reset to 0, followed by rising-edge detection. This supports asynchronous strobes.
- Only 0->1 transitions count as ticks; a held-high input is one tick.
- Reported latency rises to 3 clk from the input edge.
- Measured intervals are unchanged, because the delay is constant.
When undefined, tick_i is used directly and every high cycle is a tick.

Test Plan:
- Ticks every 4 cycles, en_i=1, ready_i=1 -> first valid_o 1 clk after the second tick, div_o=3; every later tick reports 3.
- tick_i held high, sync macro undefined -> from the second high cycle onward, div_o=0 with valid_o high every cycle.
- ready_i=0, ticks every 5 cycles -> div_o=4 held; the next tick sets overrun_o=1 with div_o still 4. A clear_i pulse returns overrun_o to 0.
- CNT_W=4, ticks at cycle 0 and cycle 20 -> stalled_o=1 from cnt=15; tick at 20 reports nothing and clears stalled_o. The next tick at 26 reports div_o=5.
- en_i dropped 2 cycles after a tick, re-raised, ticks at 100 and 107 -> state IDLE then ARM; only div_o=6 is reported, and any earlier unconsumed value is retained until accepted.
- Reset asserted while valid_o=1 and cnt=9 -> valid_o=0, div_o=0, cnt=0 immediately. With TICK_SYNC_EN defined, a 10-cycle-high pulse counts as a single tick.
